irq_sequencer: RTL
==================

Name: irq_sequencer

Overview:
- Upstream feeder of the frontend tile. It collects 16 external interrupt sources and latches them as pending, with optional edge detection.
- It applies a mask, selects the highest-priority eligible source and delivers it as a one-cycle irqload pulse with a 4-bit irqnum. The frontend uses irqnum to form irq_IP = {31'b1, irqnum, 7'b0}.
- It waits for the core's acceptance (ack) before delivering again, and redelivers on timeout.
- It holds off all delivery until the frontend's internal reset pipeline has drained.

Parameters:
- NSRC, 16, number of interrupt sources (fixed at 16 so that irqnum is 4 bits).
- RST_HOLD, 6, cycles after rst deasserts before the first delivery; covers the frontend rst0→rst_reg5 chain.
- ACK_TIMEOUT, 255, cycles to wait for irq_ack before redelivering the same irqnum. 8-bit counter.
- MIN_GAP, 2, idle cycles forced between a completed delivery and the next irqload.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- irq_src, in, 16, raw interrupt request lines, already synchronous to clk.
- edge_mode, in, 16, per-source mode: 1 = rising-edge latched, 0 = level.
- mask_wr, in, 1, write enable for the mask register.
- mask_wdata, in, 16, new mask value; a 1 enables the source.
- irq_ack, in, 1, core has accepted the delivered interrupt (entry fetched).
- irq_eoi, in, 1, end-of-interrupt strobe.
- eoi_num, in, 4, source number being completed.
- irqload, out, 1, one-cycle delivery pulse to the frontend.
- irqnum, out, 4, delivered source number; valid while irqload=1 and held stable until the next delivery.
- pending, out, 16, current pending vector, for debug.
- in_service, out, 16, in-service vector.
- busy, out, 1, high in LOAD or WAIT.

Behaviour:
- Reset values: irqload=0, irqnum=0, pending=0, in_service=0, mask=0 (all disabled), busy=0, state=HOLD, hold counter=RST_HOLD, prev_src=0.
- Edge detect: prev_src <= irq_src every cycle.
  - Edge sources: pending[i] is set on irq_src[i] & ~prev_src[i].
  - Level sources: pending[i] = irq_src[i] & ~in_service[i], evaluated each cycle.
- Eligibility: elig = pending & mask & ~in_service.
- Selection: sel = lowest index set in elig (bit 0 has the highest priority). Pure combinational priority encoder.
- States:
  - HOLD: decrement the hold counter each cycle; go to IDLE when the counter reaches 0. Edges arriving during HOLD are still latched into pending.
  - IDLE: with the gap counter at 0 and elig≠0, go to LOAD; register irqnum<=sel and clear pending[sel] if that source is edge-mode.
  - LOAD: irqload=1 for exactly this cycle; set in_service[irqnum]; go to WAIT; load the timeout counter with ACK_TIMEOUT.
  - WAIT:
    - irq_ack=1 → IDLE, gap counter <= MIN_GAP.
    - Else, timeout counter reaches 0 → back to LOAD with the same irqnum (redelivery); in_service is left unchanged.
- Latency: an edge on irq_src at cycle N (state IDLE, gap 0, source enabled) gives irqload=1 at cycle N+2 (N+1 latches pending, N+2 is LOAD).
- irq_eoi: clears in_service[eoi_num] the next cycle. An eoi for a bit that is not set is ignored.
  - If eoi and LOAD target the same bit in the same cycle, the set wins.
- irq_ack in any state other than WAIT is ignored.
- An edge on source i while in_service[i]=1 re-sets pending[i]; it is delivered after eoi.
- Mask writes take effect the next cycle.
  - Masking a source during WAIT does not cancel the outstanding delivery.
  - Pending bits of masked edge sources are retained.
- rst asserted mid-operation: return to HOLD with all reset values next cycle; an in-flight irqload is dropped. rst has priority over all other inputs.
- Counters saturate at 0 and never wrap.

Decomposition:
- Shared package irq_pkg: constant NSRC=16, the state enum (HOLD, IDLE, LOAD, WAIT), and the irqnum width constant 4.
- One sub-module, irq_prio16: a 16→4 lowest-index priority encoder with an any-valid output.
- Everything else (state machine, counters, pending/in-service registers) lives flat in irq_sequencer.

Test Plan:
- Reset hold: release rst with source 5 edge-mode, enabled and pulsed at cycle 1 → no irqload before cycle RST_HOLD(6); irqnum=5 delivered at cycle 8.
- Priority: edges on sources 3 and 9 in the same cycle, both enabled → irqnum=3 first; after ack + MIN_GAP (2 cycles), irqnum=9.
- Timeout: deliver source 2 and withhold irq_ack → second irqload with irqnum=2 exactly ACK_TIMEOUT+1 cycles after the first; in_service=16'h0004.
- Level + in_service: level source 7 held high, ack given, no eoi → no redelivery for 50 cycles; eoi_num=7 → redelivery of 7 after MIN_GAP.
- Mask: source 11 edge while mask[11]=0 → no delivery and pending[11]=1; write mask=16'h0800 → irqload with irqnum=11 two cycles after the write.
- Reset mid-WAIT: assert rst during WAIT → next cycle irqload=0, pending=0, in_service=0, busy=0, state HOLD.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt sequencer.
// Contents:
//   NSRC       number of interrupt sources (16, which makes irqnum 4 bits)
//   IRQ_NUM_W  width of an interrupt number
//   CNT_W      width of the hold / timeout / gap counters
//   irq_state_e  sequencer states
//   sat_dec()  saturating decrement shared by all counters
package irq_pkg;

  localparam int NSRC      = 16;
  localparam int IRQ_NUM_W = 4;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    HOLD = 2'd0,  // waiting for the frontend reset pipeline to drain
    IDLE = 2'd1,  // looking for an eligible source
    LOAD = 2'd2,  // irqload pulse cycle
    WAIT = 2'd3   // waiting for the core to accept the delivery
  } irq_state_e;

  // Counters stop at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

endpackage

// File: rtl/irq_prio16.sv
// 16-to-4 priority encoder; bit 0 has the highest priority.
// Ports:
//   req_i  request vector
//   idx_o  index of the lowest set bit of req_i (0 when none is set)
//   any_o  high when at least one request is set
module irq_prio16
  import irq_pkg::*;
(
  input  logic [NSRC-1:0]      req_i,
  output logic [IRQ_NUM_W-1:0] idx_o,
  output logic                 any_o
);

  // Scanning from the top down lets the lowest set index overwrite the rest.
  always_comb begin
    idx_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IRQ_NUM_W'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer feeding the frontend tile.
// Latches 16 interrupt sources as pending (edge or level per source), masks
// them, picks the lowest-numbered eligible source and delivers it as a
// one-cycle irqload pulse with irqnum. It waits for irq_ack, redelivers on
// timeout, and delivers nothing until the frontend reset pipeline has drained.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   irq_src               raw request lines (already synchronous to clk)
//   edge_mode             per source: 1 = rising-edge latched, 0 = level
//   mask_wr, mask_wdata   mask register write (1 enables a source)
//   irq_ack               core accepted the current delivery
//   irq_eoi, eoi_num      end of interrupt for source eoi_num
//   irqload, irqnum       delivery pulse and delivered source number
//   pending, in_service   debug / status vectors
//   busy                  high while in LOAD or WAIT
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int unsigned RST_HOLD    = 6,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned MIN_GAP     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      irq_src,
  input  logic [NSRC-1:0]      edge_mode,
  input  logic                 mask_wr,
  input  logic [NSRC-1:0]      mask_wdata,
  input  logic                 irq_ack,
  input  logic                 irq_eoi,
  input  logic [IRQ_NUM_W-1:0] eoi_num,
  output logic                 irqload,
  output logic [IRQ_NUM_W-1:0] irqnum,
  output logic [NSRC-1:0]      pending,
  output logic [NSRC-1:0]      in_service,
  output logic                 busy
);

  irq_state_e           state_q;
  logic [CNT_W-1:0]     hold_q, to_q, gap_q;
  logic [IRQ_NUM_W-1:0] irqnum_q;
  logic                 irqload_q, busy_q;
  logic [NSRC-1:0]      pending_q, pending_d;
  logic [NSRC-1:0]      in_service_q, in_service_d;
  logic [NSRC-1:0]      mask_q, prev_src_q;

  logic [NSRC-1:0]      rise, elig;
  logic [IRQ_NUM_W-1:0] sel;
  logic                 sel_vld, dispatch;

  assign rise = irq_src & ~prev_src_q;
  assign elig = pending_q & mask_q & ~in_service_q;

  irq_prio16 u_prio (
    .req_i (elig),
    .idx_o (sel),
    .any_o (sel_vld)
  );

  assign dispatch = (state_q == IDLE) && (gap_q == '0) && sel_vld;

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pending_d = pending_q;
    // The dispatched edge source is consumed; a fresh edge in the same cycle
    // is applied afterwards so it is not lost.
    if (dispatch && edge_mode[sel]) pending_d[sel] = 1'b0;
    pending_d = pending_d | rise;
    // Level sources simply follow the line while not in service.
    pending_d = (pending_d & edge_mode) | (irq_src & ~in_service_q & ~edge_mode);
  end

  always_comb begin
    in_service_d = in_service_q;
    if (irq_eoi) in_service_d[eoi_num] = 1'b0;
    // Applied after the eoi clear so a coincident set on the same bit wins.
    if (state_q == LOAD) in_service_d[irqnum_q] = 1'b1;
  end

  // NOTE: synchronous reset: rst is only looked at on the clock edge and
  // overrides every other input in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOLD;
      hold_q       <= CNT_W'(RST_HOLD);
      to_q         <= '0;
      gap_q        <= '0;
      irqnum_q     <= '0;
      irqload_q    <= 1'b0;
      busy_q       <= 1'b0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
      prev_src_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here is
      // computed from the values it had before this edge.
      prev_src_q   <= irq_src;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      if (mask_wr) mask_q <= mask_wdata;
      irqload_q <= 1'b0;
      gap_q     <= sat_dec(gap_q);

      case (state_q)
        HOLD: begin
          hold_q <= sat_dec(hold_q);
          if (sat_dec(hold_q) == '0) state_q <= IDLE;
        end
        IDLE: begin
          if (dispatch) begin
            state_q   <= LOAD;
            irqnum_q  <= sel;
            irqload_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= WAIT;
          to_q    <= CNT_W'(ACK_TIMEOUT);
        end
        WAIT: begin
          if (irq_ack) begin
            state_q <= IDLE;
            gap_q   <= CNT_W'(MIN_GAP);
            busy_q  <= 1'b0;
          end else begin
            to_q <= sat_dec(to_q);
            // Redeliver the same irqnum once the timeout runs out.
            if (sat_dec(to_q) == '0) begin
              state_q   <= LOAD;
              irqload_q <= 1'b1;
            end
          end
        end
        default: state_q <= HOLD;
      endcase
    end
  end

  assign irqload    = irqload_q;
  assign irqnum     = irqnum_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign busy       = busy_q;

endmodule
